// File: rtl/sub8_serial_if.sv
// Handshake and operand/result bundle for the bit-serial subtractor.
// The requester drives start/a/b/bi; the subtractor returns busy/done/d/bo.
interface sub8_serial_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bi;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] d;
    logic             bo;

    modport master (
        output start, a, b, bi,
        input  busy, done, d, bo
    );

    modport slave (
        input  start, a, b, bi,
        output busy, done, d, bo
    );
endinterface

// File: rtl/sub8_serial.sv
// Bit-serial subtractor: d = a - b - bi, one full-subtractor cell iterated LSB first.
// A borrow flip-flop carries between bits; results are published with a one-cycle done pulse.
module sub8_serial #(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    sub8_serial_if.slave  bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] d_sr;
    logic             borrow;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] d_reg;
    logic             bo_reg;
    logic             done_reg;

    logic x;
    logic y;
    logic diff;
    logic borrow_next;
    logic last_bit;
    logic accept;

    always_comb begin
        x           = a_sr[0];
        y           = b_sr[0];
        diff        = x ^ y ^ borrow;
        borrow_next = (~x & y) | (~(x ^ y) & borrow);
        last_bit    = (count == CW'(WIDTH - 1));
        accept      = (state != SHIFT) && bus.start;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // DONE also accepts a new request so operations can run back to back.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (bus.start) next_state = SHIFT;
            SHIFT:   if (last_bit)  next_state = DONE;
            DONE:    next_state = bus.start ? SHIFT : IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr     <= '0;
            b_sr     <= '0;
            d_sr     <= '0;
            borrow   <= 1'b0;
            count    <= '0;
            d_reg    <= '0;
            bo_reg   <= 1'b0;
            done_reg <= 1'b0;
        end else begin
            done_reg <= (state == DONE);
            if (state == DONE) begin
                d_reg  <= d_sr;
                bo_reg <= borrow;
            end
            if (accept) begin
                a_sr   <= bus.a;
                b_sr   <= bus.b;
                borrow <= bus.bi;
                count  <= '0;
            end else if (state == SHIFT) begin
                d_sr   <= {diff, d_sr[WIDTH-1:1]};
                a_sr   <= a_sr >> 1;
                b_sr   <= b_sr >> 1;
                borrow <= borrow_next;
                count  <= count + CW'(1);
            end
        end
    end

    assign bus.busy = (state == SHIFT);
    assign bus.done = done_reg;
    assign bus.d    = d_reg;
    assign bus.bo   = bo_reg;
endmodule

// File: tb/tb_sub8_serial.sv
// Scoreboard bench for sub8_serial: stimulus pushes expected {bo,d}, a monitor pops on done.
// Directed corner cases come first, then a batch of random vectors.
module tb_sub8_serial;
    localparam int WIDTH = 8;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    logic [WIDTH:0] sb[$];

    sub8_serial_if #(.WIDTH(WIDTH)) bus();

    sub8_serial #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Independent of stimulus: every done pulse must match the oldest outstanding result.
    always @(negedge clk) begin
        if (!rst && bus.done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_done: got done=1 with d=%0h bo=%0b, expected no done", bus.d, bus.bo);
            end else begin
                checkOutput("result", {23'd0, bus.bo, bus.d}, {23'd0, sb.pop_front()});
            end
        end
    end

    task automatic applyStimulus(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                                 input logic biv, input bit expectResult);
        @(posedge clk);
        #1;
        bus.a     = av;
        bus.b     = bv;
        bus.bi    = biv;
        bus.start = 1'b1;
        if (expectResult) sb.push_back({1'b0, av} - {1'b0, bv} - {{WIDTH{1'b0}}, biv});
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // Returns the number of falling edges until done is seen, or -1 on timeout.
    task automatic waitDone(output int n);
        n = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                n = i;
                break;
            end
        end
        if (n < 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL done_timeout: got no done in 40 cycles, expected done");
        end
    endtask

    initial begin
        int n;
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        logic rbi;

        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.bi    = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_busy", {31'd0, bus.busy}, 32'd0);
        checkOutput("reset_done", {31'd0, bus.done}, 32'd0);
        checkOutput("reset_d", {24'd0, bus.d}, 32'd0);
        checkOutput("reset_bo", {31'd0, bus.bo}, 32'd0);
        rst = 1'b0;

        // Latency is measured from the accepting edge to the falling edge showing done.
        @(posedge clk);
        #1;
        bus.a     = 8'h01;
        bus.b     = 8'h01;
        bus.bi    = 1'b0;
        bus.start = 1'b1;
        sb.push_back(9'h000);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        n = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (i == 2) checkOutput("busy_during_op", {31'd0, bus.busy}, 32'd1);
            if (bus.done === 1'b1) begin
                n = i;
                break;
            end
        end
        checkOutput("latency", n, WIDTH + 2);

        applyStimulus(8'h01, 8'h01, 1'b1, 1'b1); waitDone(n);
        applyStimulus(8'h08, 8'h07, 1'b0, 1'b1); waitDone(n);
        applyStimulus(8'h80, 8'h7F, 1'b1, 1'b1); waitDone(n);
        applyStimulus(8'h00, 8'hFF, 1'b1, 1'b1); waitDone(n);
        repeat (3) @(negedge clk);
        checkOutput("hold_d", {24'd0, bus.d}, 32'h00);
        checkOutput("hold_bo", {31'd0, bus.bo}, 32'd1);

        // A second start while busy must be ignored entirely.
        applyStimulus(8'h10, 8'h01, 1'b0, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        bus.a     = 8'hFF;
        bus.b     = 8'h00;
        bus.bi    = 1'b0;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        waitDone(n);
        checkOutput("ignored_start_d", {24'd0, bus.d}, 32'h0F);
        repeat (15) @(negedge clk);

        // Reset during bit 4: nothing published, outputs cleared.
        applyStimulus(8'h55, 8'h22, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("midreset_busy", {31'd0, bus.busy}, 32'd0);
        checkOutput("midreset_done", {31'd0, bus.done}, 32'd0);
        checkOutput("midreset_d", {24'd0, bus.d}, 32'd0);
        checkOutput("midreset_bo", {31'd0, bus.bo}, 32'd0);
        repeat (15) @(negedge clk);
        applyStimulus(8'h37, 8'h12, 1'b1, 1'b1); waitDone(n);

        // Back to back: start stays high through the DONE cycle with new operands.
        @(posedge clk);
        #1;
        bus.a     = 8'h20;
        bus.b     = 8'h05;
        bus.bi    = 1'b0;
        bus.start = 1'b1;
        sb.push_back(9'h01B);
        @(posedge clk);
        #1;
        bus.a  = 8'h03;
        bus.b  = 8'h09;
        bus.bi = 1'b1;
        sb.push_back(9'h1F9);
        waitDone(n);
        checkOutput("b2b_busy", {31'd0, bus.busy}, 32'd1);
        bus.start = 1'b0;
        waitDone(n);

        for (int k = 0; k < 1000; k++) begin
            ra  = WIDTH'($urandom_range(0, 255));
            rb  = WIDTH'($urandom_range(0, 255));
            rbi = 1'($urandom_range(0, 1));
            applyStimulus(ra, rb, rbi, 1'b1);
            waitDone(n);
        end

        repeat (5) @(negedge clk);
        checkOutput("scoreboard_empty", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
